// File: rtl/riscy_io_pkg.sv
// Shared types and constants for the RISCY I/O responder.
// Optional device parity checking is enabled with RISCY_IO_PARITY_EN.
`timescale 1ns/1ps
package riscy_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } io_state_e;

  localparam logic [1:0] ADDR_RXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_TXDATA = 2'd2;

  localparam int STAT_RX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_PERR     = 2;
  localparam int STAT_OVF      = 3;

  // A device byte is corrupt when data and parity bit together have odd weight.
  function automatic logic parity_error(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/riscy_io_fifo.sv
// Synchronous FIFO with wrap-around pointers; the extra pointer bit separates full from empty.
`timescale 1ns/1ps
module riscy_io_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/riscy_io_responder.sv
// Four-phase REQ/ACK I/O responder: RX FIFO from the device, TX holding register to it.
// Defining RISCY_IO_PARITY_EN adds DEV_PARITY and drops corrupt device bytes.
`timescale 1ns/1ps
module riscy_io_responder
  import riscy_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic       WE,
  input  logic [1:0] ADDR,
  input  logic [7:0] WDATA,
  output logic       ACK,
  output logic [7:0] IO,
  input  logic       DEV_VALID,
  input  logic [7:0] DEV_DATA,
`ifdef RISCY_IO_PARITY_EN
  input  logic       DEV_PARITY,
`endif
  output logic       DEV_READY,
  output logic       OUT_VALID,
  output logic [7:0] OUT_DATA,
  input  logic       OUT_READY
);

  io_state_e  state_q, state_d;
  logic       we_q, we_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       ack_q, ack_d;
  logic [7:0] io_q, io_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       ovf_q, ovf_d;
  logic       perr_q, perr_d;

  logic       rx_empty_s, rx_full_s, rx_pop_s, rx_push_s;
  logic [7:0] rx_dout_s;
  logic       dev_take_s, dev_bad_s;
  logic       tx_wr_s, stat_rd_s;
  logic [7:0] status_s;

  assign dev_take_s = DEV_VALID && !rx_full_s;
`ifdef RISCY_IO_PARITY_EN
  assign dev_bad_s  = parity_error(DEV_DATA, DEV_PARITY);
`else
  assign dev_bad_s  = 1'b0;
`endif
  assign rx_push_s  = dev_take_s && !dev_bad_s;

  riscy_io_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (rx_push_s),
    .pop   (rx_pop_s),
    .din   (DEV_DATA),
    .dout  (rx_dout_s),
    .empty (rx_empty_s),
    .full  (rx_full_s)
  );

  always_comb begin
    status_s                = 8'h00;
    status_s[STAT_RX_EMPTY] = rx_empty_s;
    status_s[STAT_TX_FULL]  = out_valid_q;
    status_s[STAT_PERR]     = perr_q;
    status_s[STAT_OVF]      = ovf_q;
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ack_d       = 1'b0;
    io_d        = io_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ovf_d       = ovf_q;
    perr_d      = perr_q;
    rx_pop_s    = 1'b0;
    tx_wr_s     = 1'b0;
    stat_rd_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          state_d = ST_ACCESS;
          we_d    = WE;
          addr_d  = ADDR;
          wdata_d = WDATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (we_q) begin
          tx_wr_s = (addr_q == ADDR_TXDATA);
        end else begin
          case (addr_q)
            ADDR_RXDATA: begin
              io_d     = rx_empty_s ? 8'h00 : rx_dout_s;
              rx_pop_s = !rx_empty_s;
            end
            ADDR_STATUS: begin
              io_d      = status_s;
              stat_rd_s = 1'b1;
            end
            ADDR_TXDATA: io_d = {7'b0000000, out_valid_q};
            default:     io_d = 8'h00;
          endcase
        end
      end
      ST_RESP: begin
        // ACK is withheld on the edge that leaves RESP so it falls exactly there.
        if (REQ) begin
          state_d = ST_RESP;
          ack_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clears come first so a same-edge set wins.
    if (stat_rd_s) begin
      ovf_d  = 1'b0;
      perr_d = 1'b0;
    end else begin
      ovf_d  = ovf_q;
      perr_d = perr_q;
    end

    if (tx_wr_s && (!out_valid_q || OUT_READY)) begin
      out_valid_d = 1'b1;
      out_data_d  = wdata_q;
    end else if (tx_wr_s) begin
      ovf_d = 1'b1;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (dev_take_s && dev_bad_s) begin
      perr_d = 1'b1;
    end else begin
      perr_d = perr_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= 2'd0;
      wdata_q     <= 8'h00;
      ack_q       <= 1'b0;
      io_q        <= 8'h00;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      ovf_q       <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ack_q       <= ack_d;
      io_q        <= io_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
      perr_q      <= perr_d;
    end
  end

  assign ACK       = ack_q;
  assign IO        = io_q;
  assign DEV_READY = !rx_full_s;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;

endmodule
